fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 134 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: round-robin grant of three pixel writers,
// with a full-buffer clear sweep that pre-empts arbitration.
module fb_write_arbiter #(
  parameter int unsigned MEM_SIZE    = 19200,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [44:0] req_addr,
  input  logic [71:0] req_data,
  output logic [2:0]  ack,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        err_oob,
  output logic [14:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_en
);

  localparam logic [15:0] SIZE_W    = 16'(MEM_SIZE);
  localparam logic [14:0] LAST_ADDR = 15'(MEM_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_d;
  logic [1:0]  ptr, ptr_d;
  logic [14:0] cnt, cnt_d;
  logic [2:0]  ack_d;
  logic        wr_en_d, busy_d, done_d, err_d;
  logic [14:0] wr_addr_d;
  logic [23:0] wr_data_d;

  logic [2:0]  elig;
  logic        found;
  logic [1:0]  win;
  logic [14:0] win_addr;
  logic [23:0] win_data;
  int unsigned s;

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // A requester acked this cycle is still holding req; mask it out.
    elig  = req & ~ack;
    found = 1'b0;
    win   = '0;
    s     = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      s = 32'(ptr) + i;
      if (s >= 3) s = s - 3;
      if (!found && elig[s]) begin
        found = 1'b1;
        win   = 2'(s);
      end
    end
    win_addr = req_addr[15*win +: 15];
    win_data = req_data[24*win +: 24];

    unique case (state)
      IDLE: begin
        if (clear_start) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = CLEAR_COLOR;
          busy_d    = 1'b1;
        end else if (found) begin
          ack_d[win] = 1'b1;
          ptr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
          if ({1'b0, win_addr} < SIZE_W) begin
            wr_en_d   = 1'b1;
            wr_addr_d = win_addr;
            wr_data_d = win_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        // cnt mirrors the address currently on wr_addr during the sweep
        if (cnt == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d     = cnt + 15'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = cnt + 15'd1;
          wr_data_d = CLEAR_COLOR;
          busy_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      ack        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      cnt        <= cnt_d;
      ack        <= ack_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      clear_busy <= busy_d;
      clear_done <= done_d;
      err_oob    <= err_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: vector table, clear/reset sequences and a
// randomized run against a priority-list reference model.
module tb_fb_write_arbiter;

  localparam int MEM = 19200;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [44:0] req_addr;
  logic [71:0] req_data;
  logic [2:0]  ack;
  logic        clear_start;
  logic        clear_busy, clear_done, err_oob;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;

  int checks = 0;
  int errors = 0;

  fb_write_arbiter #(.MEM_SIZE(MEM), .CLEAR_COLOR(24'h000000)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .err_oob(err_oob), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [14:0] a0, a1, a2;
    logic [23:0] d0, d1, d2;
    logic [2:0]  ack;
    logic        wen;
    logic [14:0] addr;
    logic [23:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] r, input logic [14:0] a0, a1, a2,
                       input logic [23:0] d0, d1, d2);
    req      = r;
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_ack, input logic e_wen,
                            input logic [14:0] e_addr, input logic [23:0] e_data, input logic e_err);
    check({tag, ".ack"},     32'(ack),     32'(e_ack));
    check({tag, ".wr_en"},   32'(wr_en),   32'(e_wen));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(e_addr));
    check({tag, ".wr_data"}, 32'(wr_data), 32'(e_data));
    check({tag, ".err_oob"}, 32'(err_oob), 32'(e_err));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // reference model state
  int          prio[$];
  logic [2:0]  pend;
  logic [14:0] ra[3];
  logic [23:0] rd[3];
  logic [2:0]  e_ack;
  logic        e_wen, e_err;
  logic [14:0] e_addr;
  logic [23:0] e_data;

  initial begin
    int good, writes, dones, last;
    logic [14:0] first_bad;
    logic [2:0] avail;
    int gk;

    rst = 1'b0;
    clear_start = 1'b0;
    drive(3'b000, 15'd0, 15'd0, 15'd0, 24'd0, 24'd0, 24'd0);
    tick();
    tick();
    check_outs("reset", 3'b000, 1'b0, 15'd0, 24'd0, 1'b0);
    check("reset.clear_busy", 32'(clear_busy), 32'd0);
    check("reset.clear_done", 32'(clear_done), 32'd0);
    rst = 1'b1;

    vecs[0]  = '{3'b010, 15'd0, 15'd100, 15'd0, 24'h0, 24'hFFFFFF, 24'h0, 3'b010, 1'b1, 15'd100, 24'hFFFFFF, 1'b0};
    vecs[1]  = '{3'b000, 15'd0, 15'd0, 15'd0, 24'h0, 24'h0, 24'h0, 3'b000, 1'b0, 15'd100, 24'hFFFFFF, 1'b0};
    vecs[2]  = '{3'b100, 15'd0, 15'd0, 15'd19200, 24'h0, 24'h0, 24'h123456, 3'b100, 1'b0, 15'd100, 24'hFFFFFF, 1'b1};
    vecs[3]  = '{3'b000, 15'd0, 15'd0, 15'd0, 24'h0, 24'h0, 24'h0, 3'b000, 1'b0, 15'd100, 24'hFFFFFF, 1'b0};
    vecs[4]  = '{3'b111, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b001, 1'b1, 15'd1, 24'hAA, 1'b0};
    vecs[5]  = '{3'b110, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b010, 1'b1, 15'd2, 24'hBB, 1'b0};
    vecs[6]  = '{3'b100, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b100, 1'b1, 15'd3, 24'hCC, 1'b0};
    vecs[7]  = '{3'b111, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b001, 1'b1, 15'd1, 24'hAA, 1'b0};
    vecs[8]  = '{3'b110, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b010, 1'b1, 15'd2, 24'hBB, 1'b0};
    vecs[9]  = '{3'b100, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b100, 1'b1, 15'd3, 24'hCC, 1'b0};
    vecs[10] = '{3'b000, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b000, 1'b0, 15'd3, 24'hCC, 1'b0};
    vecs[11] = '{3'b011, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b001, 1'b1, 15'd1, 24'hAA, 1'b0};
    vecs[12] = '{3'b011, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b010, 1'b1, 15'd2, 24'hBB, 1'b0};
    vecs[13] = '{3'b001, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b001, 1'b1, 15'd1, 24'hAA, 1'b0};
    vecs[14] = '{3'b000, 15'd1, 15'd2, 15'd3, 24'hAA, 24'hBB, 24'hCC, 3'b000, 1'b0, 15'd1, 24'hAA, 1'b0};
    vecs[15] = '{3'b100, 15'd1, 15'd2, 15'd19199, 24'hAA, 24'hBB, 24'hABCDEF, 3'b100, 1'b1, 15'd19199, 24'hABCDEF, 1'b0};
    vecs[16] = '{3'b101, 15'd1, 15'd2, 15'd19199, 24'hAA, 24'hBB, 24'hABCDEF, 3'b001, 1'b1, 15'd1, 24'hAA, 1'b0};
    vecs[17] = '{3'b100, 15'd1, 15'd2, 15'd19199, 24'hAA, 24'hBB, 24'hABCDEF, 3'b100, 1'b1, 15'd19199, 24'hABCDEF, 1'b0};
    vecs[18] = '{3'b000, 15'd1, 15'd2, 15'd19199, 24'hAA, 24'hBB, 24'hABCDEF, 3'b000, 1'b0, 15'd19199, 24'hABCDEF, 1'b0};

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].ack, vecs[i].wen, vecs[i].addr, vecs[i].data, vecs[i].err);
    end

    // clear collides with a request from requester 0
    clear_start = 1'b1;
    drive(3'b001, 15'd7, 15'd0, 15'd0, 24'h000077, 24'd0, 24'd0);
    tick();
    clear_start = 1'b0;
    good = 0;
    first_bad = '1;
    for (int i = 0; i < MEM; i++) begin
      if (wr_en === 1'b1 && wr_addr === 15'(i) && wr_data === 24'h0 &&
          clear_busy === 1'b1 && ack === 3'b000 && clear_done === 1'b0)
        good++;
      else if (first_bad === 15'h7FFF)
        first_bad = 15'(i);
      tick();
    end
    check("sweep.good_cycles", 32'(good), 32'(MEM));
    check("sweep.done", 32'(clear_done), 32'd1);
    check("sweep.end_wr_en", 32'(wr_en), 32'd0);
    check("sweep.end_busy", 32'(clear_busy), 32'd0);
    check("sweep.end_ack", 32'(ack), 32'd0);
    tick();
    check_outs("post_clear", 3'b001, 1'b1, 15'd7, 24'h000077, 1'b0);
    check("post_clear.done", 32'(clear_done), 32'd0);
    drive(3'b000, 15'd0, 15'd0, 15'd0, 24'd0, 24'd0, 24'd0);
    tick();
    check("post_clear.idle_ack", 32'(ack), 32'd0);

    // clear_start pulsed mid-sweep must be ignored
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    writes = 0; dones = 0; last = -1;
    for (int n = 0; n < MEM + 100; n++) begin
      if (wr_en) begin writes++; last = int'(wr_addr); end
      if (clear_done) dones++;
      clear_start = (wr_en && wr_addr == 15'd10 && clear_busy) ? 1'b1 : 1'b0;
      tick();
    end
    clear_start = 1'b0;
    check("restart.writes", 32'(writes), 32'(MEM));
    check("restart.last_addr", 32'(last), 32'(MEM - 1));
    check("restart.dones", 32'(dones), 32'd1);

    // asynchronous reset in the middle of a sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int n = 0; n < 6000 && wr_addr != 15'd5000; n++) tick();
    check("midreset.reached_5000", 32'(wr_addr), 32'd5000);
    #2 rst = 1'b0;
    #1;
    check_outs("midreset", 3'b000, 1'b0, 15'd0, 24'd0, 1'b0);
    check("midreset.busy", 32'(clear_busy), 32'd0);
    check("midreset.done", 32'(clear_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    writes = 0; dones = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (wr_en) writes++;
      if (clear_done || clear_busy) dones++;
    end
    check("midreset.no_writes", 32'(writes), 32'd0);
    check("midreset.no_done", 32'(dones), 32'd0);

    // randomized arbitration against the priority-list model
    do_reset();
    prio = '{0, 1, 2};
    pend = '0;
    e_ack = '0; e_wen = 1'b0; e_err = 1'b0; e_addr = '0; e_data = '0;
    for (int k = 0; k < 3; k++) begin ra[k] = '0; rd[k] = '0; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ((pend[k] && e_ack[k] && $urandom_range(1, 0) == 1) ||
            (!pend[k] && $urandom_range(2, 0) == 0)) begin
          pend[k] = 1'b1;
          case ($urandom_range(7, 0))
            0:       ra[k] = 15'(MEM + int'($urandom_range(200, 0)));
            1:       ra[k] = 15'(MEM - 1);
            default: ra[k] = 15'($urandom_range(MEM - 1, 0));
          endcase
          rd[k] = 24'($urandom);
        end else if (pend[k] && e_ack[k]) begin
          pend[k] = 1'b0;
        end
      end
      drive(pend, ra[0], ra[1], ra[2], rd[0], rd[1], rd[2]);

      avail = pend & ~e_ack;
      gk = -1;
      foreach (prio[j]) if (gk < 0 && avail[prio[j]]) gk = prio[j];
      e_ack = '0; e_wen = 1'b0; e_err = 1'b0;
      if (gk >= 0) begin
        e_ack[gk] = 1'b1;
        if (int'(ra[gk]) < MEM) begin
          e_wen = 1'b1; e_addr = ra[gk]; e_data = rd[gk];
        end else begin
          e_err = 1'b1;
        end
        prio = '{(gk + 1) % 3, (gk + 2) % 3, gk};
      end
      tick();
      check_outs($sformatf("rand%0d", c), e_ack, e_wen, e_addr, e_data, e_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
